uart_rx_fifo: RTL and testbench

Receive side of the 8N1 serial link to the Xilinx FPGA, paired with the existing `uart_tx` transmitter on the same link. The block synchronises the incoming line, detects start bits, samples each bit at its centre using the same `BIT_TMR_MAX` bit-period convention as `uart_tx`, and checks the stop bit. Good bytes go into a show-ahead FIFO that the top-level control FSM drains with a valid/read handshake. Framing and overrun errors are reported.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-timer width used
// by both uart_tx and uart_rx_fifo.
package uart_pkg;

  localparam int BIT_TMR_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte read handshake between the receiver FIFO (master) and its consumer (slave).
interface uart_rx_fifo_if;

  logic [7:0] DATA;
  logic       VALID;
  logic       READ;

  modport master (output DATA, output VALID, input READ);
  modport slave  (input DATA, input VALID, output READ);

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is a registered copy of the head entry,
// so a byte pushed into an empty FIFO appears on the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_rd_next;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees a slot this same cycle, so a push into a full FIFO is still accepted.
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);
  assign w_rd_next = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      // The new head is the slot being written right now when the FIFO drains to it.
      if (w_push && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0])) begin
        r_dout <= din;
      end else begin
        r_dout <= r_mem[w_rd_next[AW-1:0]];
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: line synchroniser, mid-bit sampling FSM and stop-bit
// check, feeding good bytes into a show-ahead FIFO with framing/overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [BIT_TMR_W-1:0] BIT_TMR_MAX,
  input  logic                 UART_RX,
  uart_rx_fifo_if.master       rd,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  input  logic                 CLR_ERR
);

  rx_state_t            r_state;
  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [BIT_TMR_W-1:0] r_tmr;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_fall;
  logic                 w_expired;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_dout;

  assign w_fall    = r_rx_prev && !r_rx_s;
  assign w_expired = (r_tmr == '0);
  assign w_push    = (r_state == ST_STOP) && w_expired && r_rx_s;
  assign w_pop     = rd.READ && !w_empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= UART_RX;
      r_rx_s      <= r_sync1;
      r_rx_prev   <= r_rx_s;
      r_frame_err <= 1'b0;
      if (!w_expired) begin
        r_tmr <= r_tmr - 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_tmr   <= BIT_TMR_MAX >> 1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          // A start bit that is high again at its centre was only a glitch.
          if (w_expired) begin
            if (!r_rx_s) begin
              r_tmr     <= BIT_TMR_MAX;
              r_bit_idx <= '0;
              r_state   <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_expired) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_tmr     <= BIT_TMR_MAX;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_expired) begin
            if (r_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (r_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun: a new set beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (CLR_ERR) begin
      r_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .srst  (RESET),
    .push  (w_push),
    .din   (r_shift),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_dout)
  );

  assign rd.DATA   = w_dout;
  assign rd.VALID  = !w_empty;
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based model of the FIFO and
// flags fed by the frames the bench itself serialises onto the line.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [BIT_TMR_W-1:0] bit_tmr_max = 24'd11;
  logic                 uart_rx = 1'b1;
  logic                 clr_err = 1'b0;
  logic                 frame_err;
  logic                 overrun;

  uart_rx_fifo_if rd_if ();

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .BIT_TMR_MAX (bit_tmr_max),
    .UART_RX     (uart_rx),
    .rd          (rd_if),
    .FRAME_ERR   (frame_err),
    .OVERRUN     (overrun),
    .CLR_ERR     (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] data;
    bit         good;
  } ev_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ferr_count = 0;
  int         last_push_edge = 0;
  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  bit         rdone;

  logic [7:0] stream [16] = '{8'h4D, 8'h45, 8'h47, 8'h41, 8'h70, 8'h68, 8'h6F, 8'h6E,
                              8'h65, 8'h20, 8'h43, 8'h54, 8'h4C, 8'h30, 8'h0D, 8'h0A};
  int         mopts [4] = '{4, 7, 11, 15};

  // Reference model: the stop-bit sample of each frame lands on a known edge;
  // the FIFO is a plain queue of bytes.
  always @(posedge clk) begin : model
    bit  pop;
    bit  set_ovr;
    ev_t ev;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      set_ovr = 1'b0;
      m_ferr  = 1'b0;
      pop = rd_if.READ && (mq.size() > 0);
      if (pop) begin
        $display("[TB] cyc %0d pop %02h", cyc, mq[0]);
        void'(mq.pop_front());
      end
      while (pend.size() > 0 && pend[0].edge_n < cyc) void'(pend.pop_front());
      if (pend.size() > 0 && pend[0].edge_n == cyc) begin
        ev = pend.pop_front();
        if (!ev.good) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(ev.data);
        else set_ovr = 1'b1;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit         ok;
    logic [7:0] exp_d;
    if (cyc >= 1) begin
      exp_d = (mq.size() > 0) ? mq[0] : 8'h00;
      ok = (rd_if.VALID === (mq.size() > 0)) && (frame_err === m_ferr) &&
           (overrun === m_ovr) && ((mq.size() == 0) || (rd_if.DATA === exp_d));
      tests++;
      if (!ok) begin
        fails++;
        if (fails < 20)
          $display("FAIL cycle_cmp cyc=%0d: got VALID=%b DATA=%02h FRAME_ERR=%b OVERRUN=%b, want VALID=%b DATA=%02h FRAME_ERR=%b OVERRUN=%b",
                   cyc, rd_if.VALID, rd_if.DATA, frame_err, overrun, (mq.size() > 0), exp_d, m_ferr, m_ovr);
      end
    end
  end

  always @(negedge clk) if (frame_err === 1'b1) ferr_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the line falls immediately and every cell lasts M+1 cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int  m;
    ev_t ev;
    m = int'(bit_tmr_max);
    uart_rx   = 1'b0;
    ev.edge_n = cyc + 1 + 3 + (m >> 1) + 9 * (m + 1);
    ev.data   = b;
    ev.good   = stop_ok;
    pend.push_back(ev);
    last_push_edge = ev.edge_n;
    $display("[TB] cyc %0d send %02h stop=%0d M=%0d", cyc, b, stop_ok, m);
    repeat (m + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (m + 1) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (m + 1) @(negedge clk);
  endtask

  task automatic pop_one();
    rd_if.READ = 1'b1;
    @(negedge clk);
    rd_if.READ = 1'b0;
  endtask

  task automatic drain(output int n, output logic [7:0] last);
    n = 0;
    last = 8'h00;
    for (int k = 0; k < 100; k++) begin
      if (!rd_if.VALID) break;
      last = rd_if.DATA;
      n++;
      rd_if.READ = 1'b1;
      @(negedge clk);
    end
    rd_if.READ = 1'b0;
  endtask

  initial begin : stim
    int         n;
    int         f0;
    int         m;
    logic [7:0] last;
    rd_if.READ = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", rd_if.VALID, 0);
    check("rst_data", rd_if.DATA, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    idle(5);

    // single byte
    send_frame(8'h4D, 1'b1);
    idle(2);
    check("single_valid", rd_if.VALID, 1);
    check("single_data", rd_if.DATA, 8'h4D);
    pop_one();
    check("single_pop_valid", rd_if.VALID, 0);
    check("single_no_ferr", ferr_count, 0);

    // back-to-back stream fills the FIFO, then one more overruns
    for (int i = 0; i < 16; i++) send_frame(stream[i], 1'b1);
    idle(2);
    check("stream_head", rd_if.DATA, 8'h4D);
    check("stream_no_ovr", overrun, 0);
    send_frame(8'h55, 1'b1);
    idle(2);
    check("ovr_set", overrun, 1);
    check("ovr_head", rd_if.DATA, 8'h4D);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_clear", overrun, 0);

    // full FIFO, pop on the stop-sample cycle of 0x7E
    last_push_edge = 0;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        int k = 0;
        while ((last_push_edge == 0 || cyc < last_push_edge - 1) && k < 1000) begin
          @(negedge clk);
          k++;
        end
        check("pop_at_push_reached", cyc, last_push_edge - 1);
        rd_if.READ = 1'b1;
        @(negedge clk);
        rd_if.READ = 1'b0;
      end
    join
    idle(2);
    check("full_pop_push_ovr", overrun, 0);
    check("full_pop_push_head", rd_if.DATA, 8'h45);
    drain(n, last);
    check("full_pop_push_count", n, 16);
    check("full_pop_push_tail", last, 8'h7E);

    // framing error then held-low line
    f0 = ferr_count;
    send_frame(8'hA5, 1'b0);
    repeat (40 * 12) @(negedge clk);
    check("ferr_single_pulse", ferr_count - f0, 1);
    check("ferr_no_push", rd_if.VALID, 0);
    idle(24);
    send_frame(8'h3C, 1'b1);
    idle(2);
    check("after_break_data", rd_if.DATA, 8'h3C);
    pop_one();

    // 3-cycle glitch
    f0 = ferr_count;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_no_push", rd_if.VALID, 0);
    check("glitch_no_ferr", ferr_count - f0, 0);
    send_frame(8'h99, 1'b1);
    idle(2);
    check("after_glitch_data", rd_if.DATA, 8'h99);
    pop_one();

    // reset during bit 4 of 0xFF with a byte waiting in the FIFO
    send_frame(8'h66, 1'b1);
    idle(2);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (12 * 5 + 6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", rd_if.VALID, 0);
        check("midrst_data", rd_if.DATA, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
      end
    join
    idle(12);
    send_frame(8'h12, 1'b1);
    idle(2);
    check("after_rst_data", rd_if.DATA, 8'h12);
    pop_one();

    // randomized bursts against the model
    for (int burst = 0; burst < 6; burst++) begin
      bit_tmr_max = 24'(mopts[$urandom_range(3)]);
      m = int'(bit_tmr_max);
      idle(20);
      rdone = 1'b0;
      fork
        begin
          for (int f = 0; f < 10; f++) begin
            logic [7:0] b;
            bit         good;
            b    = 8'($urandom);
            good = ($urandom_range(7) != 0);
            send_frame(b, good);
            if (!good) idle(m + 1);
            else idle(int'($urandom_range(2)) * (m + 1));
          end
          idle(30);
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            rd_if.READ = ($urandom_range(2) == 0);
            clr_err    = ($urandom_range(15) == 0);
            @(negedge clk);
          end
          rd_if.READ = 1'b0;
          clr_err    = 1'b0;
        end
      join
    end
    drain(n, last);
    idle(5);
    check("final_empty", rd_if.VALID, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
